// File: rtl/lcd_scanout.sv
// LCD scan-out timing generator with frame-buffer read pointer.
// Produces sync/blank flags and RGB888 from a 15-bit RGB555 frame buffer.
module lcd_scanout #(
  parameter int H_ACTIVE = 160,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 32,
  parameter int V_ACTIVE = 144,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        on,
  output logic [14:0] rd_addr,
  input  logic [14:0] rd_data,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        hblank,
  output logic        vblank,
  output logic        de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [14:0]   ptr;
  logic          h_act;
  logic          v_act;
  logic          act;
  logic          hs_n;
  logic          vs_n;

  // Decode region flags of the current raster position.
  always_comb begin
    h_act = (hcnt < H_ACT);
    v_act = (vcnt < V_ACT);
    act   = h_act && v_act;
    hs_n  = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vs_n  = (vcnt >= VS_BEG) && (vcnt < VS_END);
  end

  // Raster counters: advance one pixel per ce_pix, wrap line then frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce_pix) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) vcnt <= '0;
        else                vcnt <= vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Linear read pointer: counts active pixels, cleared in vblank and when off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (ce_pix) begin
      if (!on || !v_act) ptr <= '0;
      else if (h_act)    ptr <= ptr + 15'd1;
    end
  end

  assign rd_addr = ptr;

  // Output stage: register flags and colour of the current position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      hs     <= 1'b0;
      vs     <= 1'b0;
      de     <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
    end else if (ce_pix) begin
      hblank <= !h_act;
      vblank <= !v_act;
      de     <= act;
      hs     <= hs_n;
      vs     <= vs_n;
      if (act && on) begin
        r <= {rd_data[4:0],   rd_data[4:2]};
        g <= {rd_data[9:5],   rd_data[9:7]};
        b <= {rd_data[14:10], rd_data[14:12]};
      end else if (act) begin
        r <= 8'hFF;
        g <= 8'hFF;
        b <= 8'hFF;
      end else begin
        r <= 8'h00;
        g <= 8'h00;
        b <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: directed vector table over one full frame,
// on toggling, ce_pix stall and mid-line reset.
module tb_lcd_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        on;
  logic [14:0] rd_addr;
  logic [14:0] rd_data;
  logic [7:0]  r, g, b;
  logic        hs, vs, hblank, vblank, de;

  lcd_scanout dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .on(on),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .r(r), .g(g), .b(b),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .de(de)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with mem[i] = i.
  always @(posedge clk) rd_data <= rd_addr;

  typedef struct {
    int          k;
    logic        on;
    logic        hold;
    logic [43:0] exp;
  } vec_t;

  vec_t tbl[28];

  int n_vec = 0;
  int n_bad = 0;
  int ce_count = 0;
  int de_cnt = 0;
  int de_f1 = -1;
  int last_rise = -1;
  int hs_len = 0;
  int vs_len = 0;
  logic hs_prev = 1'b0;
  logic vs_prev = 1'b0;

  function automatic logic [43:0] mk(
    input logic [14:0] a, input logic [7:0] rr, input logic [7:0] gg,
    input logic [7:0] bb, input logic h, input logic v, input logic d,
    input logic hb, input logic vb);
    return {a, rr, gg, bb, h, v, d, hb, vb};
  endfunction

  function automatic logic [43:0] actual();
    return {rd_addr, r, g, b, hs, vs, de, hblank, vblank};
  endfunction

  task automatic cmp(input string name, input int idx, input logic [43:0] e);
    logic [43:0] a;
    a = actual();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] got addr=%0d rgb=%h hs/vs/de/hb/vb=%b want addr=%0d rgb=%h hs/vs/de/hb/vb=%b",
               name, idx, a[43:29], a[28:5], a[4:0], e[43:29], e[28:5], e[4:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at ce %0d got %0d want %0d", name, ce_count, got, want);
    end
  endtask

  // One pixel enable pulse followed by one idle clock, then monitor.
  task automatic step();
    @(negedge clk) ce_pix = 1'b1;
    @(negedge clk) ce_pix = 1'b0;
    ce_count++;
    if (de) de_cnt++;
    if (ce_count == 33264) de_f1 = de_cnt;
    if (hs && !hs_prev) begin
      if (last_rise >= 0) check_int("hs_period", ce_count - last_rise, 216);
      last_rise = ce_count;
    end
    if (hs) hs_len++;
    else if (hs_prev) begin
      check_int("hs_width", hs_len, 8);
      hs_len = 0;
    end
    if (vs) vs_len++;
    else if (vs_prev) begin
      check_int("vs_width", vs_len, 648);
      vs_len = 0;
    end
    hs_prev = hs;
    vs_prev = vs;
  endtask

  initial begin
    logic [43:0] rst_exp;
    rst_exp = mk(15'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1);

    tbl[0]  = '{1,     1, 0, mk(15'd1,     8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0)};
    tbl[1]  = '{32,    1, 0, mk(15'd32,    8'hFF, 8'h00, 8'h00, 0, 0, 1, 0, 0)};
    tbl[2]  = '{33,    1, 0, mk(15'd33,    8'h00, 8'h08, 8'h00, 0, 0, 1, 0, 0)};
    tbl[3]  = '{160,   1, 0, mk(15'd160,   8'hFF, 8'h21, 8'h00, 0, 0, 1, 0, 0)};
    tbl[4]  = '{161,   1, 0, mk(15'd160,   8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0)};
    tbl[5]  = '{176,   1, 0, mk(15'd160,   8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0)};
    tbl[6]  = '{177,   1, 0, mk(15'd160,   8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 0)};
    tbl[7]  = '{184,   1, 0, mk(15'd160,   8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 0)};
    tbl[8]  = '{185,   1, 0, mk(15'd160,   8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0)};
    tbl[9]  = '{217,   1, 0, mk(15'd161,   8'h00, 8'h29, 8'h00, 0, 0, 1, 0, 0)};
    tbl[10] = '{31047, 1, 0, mk(15'd23039, 8'hF7, 8'h7B, 8'hB5, 0, 0, 1, 0, 0)};
    tbl[11] = '{31048, 1, 0, mk(15'd23040, 8'hFF, 8'h7B, 8'hB5, 0, 0, 1, 0, 0)};
    tbl[12] = '{31049, 1, 0, mk(15'd23040, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0)};
    tbl[13] = '{31104, 1, 0, mk(15'd23040, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0)};
    tbl[14] = '{31105, 1, 0, mk(15'd0,     8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1)};
    tbl[15] = '{31752, 1, 0, mk(15'd0,     8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1)};
    tbl[16] = '{31753, 1, 0, mk(15'd0,     8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1)};
    tbl[17] = '{32400, 1, 0, mk(15'd0,     8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 1)};
    tbl[18] = '{32401, 1, 0, mk(15'd0,     8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1)};
    tbl[19] = '{33264, 1, 0, mk(15'd0,     8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1)};
    tbl[20] = '{33265, 1, 0, mk(15'd1,     8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0)};
    tbl[21] = '{33480, 1, 0, mk(15'd160,   8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0)};
    tbl[22] = '{33481, 0, 0, mk(15'd0,     8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 0, 0)};
    tbl[23] = '{33490, 0, 0, mk(15'd0,     8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 0, 0)};
    tbl[24] = '{33491, 1, 0, mk(15'd1,     8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0)};
    tbl[25] = '{33492, 1, 1, mk(15'd2,     8'h08, 8'h00, 8'h00, 0, 0, 1, 0, 0)};
    tbl[26] = '{33493, 1, 0, mk(15'd3,     8'h10, 8'h00, 8'h00, 0, 0, 1, 0, 0)};
    tbl[27] = '{33580, 1, 0, mk(15'd90,    8'hCE, 8'h10, 8'h00, 0, 0, 1, 0, 0)};

    reset  = 1'b1;
    ce_pix = 1'b0;
    on     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_state", 0, rst_exp);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      on = tbl[i].on;
      while (ce_count < tbl[i].k) step();
      cmp("vec", i, tbl[i].exp);
      if (tbl[i].hold) begin
        repeat (500) @(negedge clk);
        cmp("ce_hold", i, tbl[i].exp);
      end
    end

    check_int("de_per_frame", de_f1, 23040);

    // Mid-line reset at (100,1): asynchronous clear, restart at (0,0).
    #1 reset = 1'b1;
    #1 cmp("async_reset", 0, rst_exp);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    ce_count  = 0;
    last_rise = -1;
    hs_len    = 0;
    vs_len    = 0;
    hs_prev   = 1'b0;
    vs_prev   = 1'b0;
    cmp("post_reset_idle", 0, rst_exp);
    step();
    cmp("post_reset_px", 0, mk(15'd1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0));
    step();
    cmp("post_reset_px", 1, mk(15'd2, 8'h08, 8'h00, 8'h00, 0, 0, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
